xor_tree_pipe: RTL and testbench
================================

# xor_tree_pipe

Pipelined, parametrised successor to the combinational XOR tree used in the GF(2^31) PRNG datapath. It XOR-reduces `N_VEC` vectors of `WIDTH` bits through a registered binary tree, one tree level per cycle. A valid/ready stream interface with full backpressure wraps the tree. An optional output accumulator XOR-folds multi-beat frames delimited by `in_last`, so wide GF(2) matrix-row sums can be streamed in slices.

## Interface
Parameters:
- `N_VEC`, 5, number of input vectors per beat (≥2)
- `WIDTH`, 31, bit-length per vector
- `BEAT_W`, 8, width of the frame beat counter

Ports:
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `in_vectors`  input  N_VEC*WIDTH  packed vectors; vector i at bits [i*WIDTH +: WIDTH]
- `in_valid`  input  1  beat present
- `in_last`  input  1  beat closes the current frame
- `in_ready`  output  1  block accepts a beat this cycle
- `out_xor`  output  WIDTH  XOR of all vectors of all beats in the frame
- `out_beats`  output  BEAT_W  number of beats in the emitted frame, saturating
- `out_valid`  output  1  result present
- `out_ready`  input  1  downstream accepts result

## Operation
- Beat accepted when `in_valid && in_ready`.
- `LEVELS = $clog2(N_VEC)`. Level k pairs adjacent nodes (0^1, 2^3, …) into registers. An unpaired last node is registered unchanged. Each level carries a valid bit and a last bit.
- The tree output feeds the accumulator stage, which holds `acc` (WIDTH) and `cnt` (BEAT_W):
  - On a valid, non-last tree result: `acc <= acc ^ res`, `cnt <= sat(cnt+1)`.
  - On a valid, last tree result: `out_xor <= acc ^ res`, `out_beats <= sat(cnt+1)`, `out_valid <= 1`, `acc <= 0`, `cnt <= 0`.
- `sat()` clamps at all-ones; it never wraps to 0.
- Stall: `stall = out_valid && !out_ready`. While stalled, all tree registers, `acc`, `cnt` and outputs hold. `in_ready = !stall`, a combinational path from `out_ready`.
- When `out_valid && out_ready` and no new last result arrives in the same cycle, `out_valid <= 0`. `out_xor` and `out_beats` keep their values.
- A new last result arriving in the same cycle the current result is consumed loads directly. This gives back-to-back output with no bubble.
- `in_vectors`/`in_last` are ignored when `in_valid` is 0. Invalid tree slots never modify `acc`.

## Timing
- Reset: all tree data, valid and last registers are 0. `acc = 0`, `cnt = 0`, `out_xor = 0`, `out_beats = 0`, `out_valid = 0`, and `in_ready = 1`.
- Latency: a beat accepted at edge t produces its last-beat result with `out_valid` high after edge t+LEVELS+1. For `N_VEC = 5` this is 4 cycles.
- Throughput: one beat per cycle when `out_ready` is held high.
- Reset mid-frame or mid-stall discards in-flight beats, the partial `acc`/`cnt` and any pending output. The next accepted beat starts a fresh frame.
- Simultaneous `rst` and handshake: reset wins and the beat is dropped.

## Configuration
- `XOR_TREE_PIPE_ACCUM_EN` defined: multi-beat accumulation as described; `in_last` is honoured.
- Not defined:
  - `in_last` is ignored and every beat is treated as last.
  - `acc`/`cnt` are not implemented.
  - `out_xor` is the per-beat tree result and `out_beats` is constant 1 after the first output (0 at reset).
  - Latency and stall rules are unchanged.

## Test plan
- Reset: hold `rst` 2 cycles -> `out_valid=0`, `out_xor=0`, `out_beats=0`, `in_ready=1`.
- Single beat, N_VEC=5, WIDTH=31, `in_vectors={31'd478163327,31'd107420369,31'd1181241943,31'd1051802512,31'd958682846}`, `in_last=1` -> `out_valid` 4 cycles later with `out_xor=31'd1528435895` and `out_beats=1`.
- Two-beat frame (ACCUM_EN): the above beat with `in_last=0`, then `{0,0,0,0,31'd1}` with `in_last=1` -> single output `out_xor=31'd1528435894`, `out_beats=2`; no output after the first beat.
- Backpressure: 10 consecutive last beats with `out_ready` low for 5 cycles after the first output ->
  - `in_ready` is low exactly while stalled;
  - `out_xor` is stable during the stall;
  - 10 outputs appear in order with none lost or duplicated.
- Reset mid-frame (ACCUM_EN): one non-last beat of the known vectors, `rst` for 1 cycle, then an all-zero beat with `in_last=1` -> `out_xor=0`, `out_beats=1`.
- Macro undefined: 3 beats with `in_last=0` -> 3 outputs, each equal to its own beat's XOR, `out_beats=1`.

Source files
------------

// File: rtl/xor_tree_pipe.sv
// xor_tree_pipe: registered binary XOR tree with valid/ready backpressure; define XOR_TREE_PIPE_ACCUM_EN for multi-beat frame accumulation
module xor_tree_pipe #(
    parameter int N_VEC  = 5,
    parameter int WIDTH  = 31,
    parameter int BEAT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_VEC*WIDTH-1:0] in_vectors,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_xor,
    output logic [BEAT_W-1:0]      out_beats,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int LEVELS = $clog2(N_VEC);
`ifdef XOR_TREE_PIPE_ACCUM_EN
    localparam bit ACCUM = 1'b1;
`else
    localparam bit ACCUM = 1'b0;
`endif
    logic             stall;
    logic [WIDTH-1:0] res;
    logic             res_v;
    logic             res_l;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    genvar k, j;
    generate
        for (k = 0; k <= LEVELS; k++) begin : lv
            localparam int NK = (N_VEC + (1 << k) - 1) >> k;
            logic [NK*WIDTH-1:0] d;
            logic                v;
            logic                l;
            if (k == 0) begin : g
                // Input stage: capture an accepted beat; without accumulation every beat closes its own frame
                always_ff @(posedge clk) begin
                    if (rst) begin
                        d <= '0;
                        v <= 1'b0;
                        l <= 1'b0;
                    end else if (!stall) begin
                        d <= in_valid ? in_vectors : '0;
                        v <= in_valid;
                        l <= in_valid && (in_last || !ACCUM);
                    end
                end
            end else begin : g
                localparam int NP = (N_VEC + (1 << (k - 1)) - 1) >> (k - 1);
                logic [NK*WIDTH-1:0] nxt;
                for (j = 0; j < NK; j++) begin : n
                    if (2 * j + 1 < NP) begin : p
                        assign nxt[j*WIDTH +: WIDTH] = lv[k-1].d[2*j*WIDTH +: WIDTH] ^ lv[k-1].d[(2*j+1)*WIDTH +: WIDTH];
                    end else begin : u
                        assign nxt[j*WIDTH +: WIDTH] = lv[k-1].d[2*j*WIDTH +: WIDTH];
                    end
                end
                // Tree level: pairwise XOR of the previous level, odd node passed through
                always_ff @(posedge clk) begin
                    if (rst) begin
                        d <= '0;
                        v <= 1'b0;
                        l <= 1'b0;
                    end else if (!stall) begin
                        d <= nxt;
                        v <= lv[k-1].v;
                        l <= lv[k-1].l;
                    end
                end
            end
        end
    endgenerate
    assign res   = lv[LEVELS].d;
    assign res_v = lv[LEVELS].v;
    assign res_l = lv[LEVELS].l;
`ifdef XOR_TREE_PIPE_ACCUM_EN
    logic [WIDTH-1:0]  acc;
    logic [BEAT_W-1:0] cnt;
    logic [BEAT_W-1:0] cnt_inc;
    assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
    // Output stage: fold beats into acc until the last one, then publish the frame sum and beat count
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_xor   <= '0;
            out_beats <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= res_v && res_l;
            if (res_v && res_l) begin
                out_xor   <= acc ^ res;
                out_beats <= cnt_inc;
                acc       <= '0;
                cnt       <= '0;
            end else if (res_v) begin
                acc <= acc ^ res;
                cnt <= cnt_inc;
            end
        end
    end
`else
    // Output stage: publish each beat's tree result directly
    always_ff @(posedge clk) begin
        if (rst) begin
            out_xor   <= '0;
            out_beats <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= res_v && res_l;
            if (res_v && res_l) begin
                out_xor   <= res;
                out_beats <= BEAT_W'(1);
            end
        end
    end
`endif
endmodule

// File: tb/tb_xor_tree_pipe.sv
// tb_xor_tree_pipe: directed self-checking bench for xor_tree_pipe (accumulation scenarios under XOR_TREE_PIPE_ACCUM_EN)
module tb_xor_tree_pipe;
    localparam int N = 5;
    localparam int W = 31;
    localparam int B = 8;
    localparam logic [N*W-1:0] KV  = {31'd478163327, 31'd107420369, 31'd1181241943, 31'd1051802512, 31'd958682846};
    localparam logic [N*W-1:0] ONE = {31'd0, 31'd0, 31'd0, 31'd0, 31'd1};
    localparam logic [W-1:0]   KX  = 31'd1528435895;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_vectors;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [W-1:0]   out_xor;
    logic [B-1:0]   out_beats;
    logic           out_valid;
    logic           out_ready;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] qx[$];
    logic [B-1:0] qb[$];

    xor_tree_pipe #(.N_VEC(N), .WIDTH(W), .BEAT_W(B)) dut (
        .clk(clk), .rst(rst), .in_vectors(in_vectors), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_xor(out_xor), .out_beats(out_beats), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [N*W-1:0] mk(input int i);
        logic [N*W-1:0] v;
        v = '0;
        v[0 +: W]   = W'(i);
        v[2*W +: W] = W'(i << 8);
        v[4*W +: W] = 31'h40000000;
        return v;
    endfunction

    function automatic logic [W-1:0] mk_x(input int i);
        return 31'h40000000 | W'(i << 8) | W'(i);
    endfunction

    task automatic beat(input logic [N*W-1:0] v, input logic last);
        in_vectors = v;
        in_valid   = 1'b1;
        in_last    = last;
        @(posedge clk); #1;
    endtask

    task automatic collect(input int cycles);
        qx.delete();
        qb.delete();
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (out_valid && out_ready) begin
                qx.push_back(out_xor);
                qb.push_back(out_beats);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_vectors = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_xor !== '0) begin errors++; $display("FAIL reset_out_xor: got %0d expected 0", out_xor); end
        checks++; if (out_beats !== '0) begin errors++; $display("FAIL reset_out_beats: got %0d expected 0", out_beats); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        rst = 1'b1; in_vectors = KV; in_valid = 1'b1; in_last = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        collect(8);
        checks++; if (qx.size() != 0) begin errors++; $display("FAIL reset_drops_beat: got %0d outputs expected 0", qx.size()); end
    endtask

    task automatic test_single;
        beat(KV, 1'b1);
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: cycle %0d got %0b expected 0", c, out_valid); end
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got out_valid %0b expected 1", out_valid); end
        checks++; if (out_xor !== KX) begin errors++; $display("FAIL single_xor: got %0d expected %0d", out_xor, KX); end
        checks++; if (out_beats !== 8'd1) begin errors++; $display("FAIL single_beats: got %0d expected 1", out_beats); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_consumed: got out_valid %0b expected 0", out_valid); end
        checks++; if (out_xor !== KX) begin errors++; $display("FAIL single_xor_kept: got %0d expected %0d", out_xor, KX); end
    endtask

    task automatic test_backpressure;
        int got;
        int stall_left;
        int stall_seen;
        logic started;
        logic [W-1:0] hold;
        got = 0; stall_left = 0; stall_seen = 0; started = 1'b0; hold = '0;
        qx.delete();
        fork
            begin
                int i;
                logic ok;
                i = 0;
                for (int c = 0; c < 300 && i < 10; c++) begin
                    in_vectors = mk(i); in_valid = 1'b1; in_last = 1'b1;
                    @(negedge clk); ok = in_ready;
                    @(posedge clk); #1;
                    if (ok) i++;
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 300 && got < 10; c++) begin
                    @(posedge clk); #1;
                    if (out_valid && !started) begin started = 1'b1; stall_left = 5; hold = out_xor; end
                    out_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                    #1;
                    checks++; if (in_ready !== !(out_valid && !out_ready)) begin errors++; $display("FAIL bp_in_ready: got %0b with out_valid %0b out_ready %0b", in_ready, out_valid, out_ready); end
                    if (out_valid && !out_ready) begin
                        stall_seen++;
                        checks++; if (out_xor !== hold) begin errors++; $display("FAIL bp_stable: got %0d expected %0d", out_xor, hold); end
                    end
                    if (out_valid && out_ready) begin qx.push_back(out_xor); got++; end
                end
                out_ready = 1'b1;
            end
        join
        checks++; if (stall_seen != 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 5", stall_seen); end
        checks++;
        if (qx.size() != 10) begin
            errors++; $display("FAIL bp_count: got %0d outputs expected 10", qx.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (qx[i] !== mk_x(i)) begin errors++; $display("FAIL bp_order: output %0d got %0h expected %0h", i, qx[i], mk_x(i)); end
            end
        end
        collect(8);
        checks++; if (qx.size() != 0) begin errors++; $display("FAIL bp_duplicate: got %0d extra outputs expected 0", qx.size()); end
    endtask

`ifdef XOR_TREE_PIPE_ACCUM_EN
    task automatic test_accum;
        beat(KV, 1'b0);
        beat(ONE, 1'b1);
        in_valid = 1'b0;
        collect(8);
        checks++;
        if (qx.size() != 1) begin
            errors++; $display("FAIL accum_count: got %0d outputs expected 1", qx.size());
        end else begin
            if (qx[0] !== 31'd1528435894) begin errors++; $display("FAIL accum_xor: got %0d expected 1528435894", qx[0]); end
            if (qb[0] !== 8'd2) begin errors++; $display("FAIL accum_beats: got %0d expected 2", qb[0]); end
        end
        for (int i = 0; i < 301; i++) beat(ONE, i == 300);
        in_valid = 1'b0;
        collect(8);
        checks++;
        if (qx.size() != 1) begin
            errors++; $display("FAIL sat_count: got %0d outputs expected 1", qx.size());
        end else begin
            if (qx[0] !== 31'd1) begin errors++; $display("FAIL sat_xor: got %0d expected 1", qx[0]); end
            if (qb[0] !== 8'd255) begin errors++; $display("FAIL sat_beats: got %0d expected 255", qb[0]); end
        end
    endtask

    task automatic test_reset_midframe;
        beat(KV, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        beat('0, 1'b1);
        in_valid = 1'b0;
        collect(8);
        checks++;
        if (qx.size() != 1) begin
            errors++; $display("FAIL midrst_count: got %0d outputs expected 1", qx.size());
        end else begin
            if (qx[0] !== '0) begin errors++; $display("FAIL midrst_xor: got %0d expected 0", qx[0]); end
            if (qb[0] !== 8'd1) begin errors++; $display("FAIL midrst_beats: got %0d expected 1", qb[0]); end
        end
    endtask
`else
    task automatic test_no_accum;
        beat(KV, 1'b0);
        beat(ONE, 1'b0);
        beat(mk(7), 1'b0);
        in_valid = 1'b0;
        collect(8);
        checks++;
        if (qx.size() != 3) begin
            errors++; $display("FAIL noacc_count: got %0d outputs expected 3", qx.size());
        end else begin
            if (qx[0] !== KX) begin errors++; $display("FAIL noacc_xor0: got %0d expected %0d", qx[0], KX); end
            if (qx[1] !== 31'd1) begin errors++; $display("FAIL noacc_xor1: got %0d expected 1", qx[1]); end
            if (qx[2] !== mk_x(7)) begin errors++; $display("FAIL noacc_xor2: got %0h expected %0h", qx[2], mk_x(7)); end
            for (int i = 0; i < 3; i++) begin
                if (qb[i] !== 8'd1) begin errors++; $display("FAIL noacc_beats: output %0d got %0d expected 1", i, qb[i]); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
`ifdef XOR_TREE_PIPE_ACCUM_EN
        test_accum();
        test_reset_midframe();
`else
        test_no_accum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
